// File: rtl/leg_branch_pkg.sv
// Shared definitions for the LEG branch controller: condition codes,
// the sequencer state type and a saturating increment helper.
package leg_branch_pkg;

  localparam logic [5:0] COND_EQ  = 6'h20;
  localparam logic [5:0] COND_NE  = 6'h21;
  localparam logic [5:0] COND_LTU = 6'h22;
  localparam logic [5:0] COND_LEU = 6'h23;
  localparam logic [5:0] COND_GTU = 6'h24;
  localparam logic [5:0] COND_GEU = 6'h25;
  localparam logic [5:0] COND_LTS = 6'h26;
  localparam logic [5:0] COND_LES = 6'h27;
  localparam logic [5:0] COND_GTS = 6'h28;
  localparam logic [5:0] COND_GES = 6'h29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/leg_branch_if.sv
// Branch request channel into the LEG branch controller: a valid/ready
// handshake carrying the condition opcode, both operands and the target.
interface leg_branch_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_op;
  logic [DATA_W-1:0] in_arg1;
  logic [DATA_W-1:0] in_arg2;
  logic [PC_W-1:0]   in_target;

  modport master (
    output in_valid, in_op, in_arg1, in_arg2, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_arg1, in_arg2, in_target,
    output in_ready
  );

endinterface

// File: rtl/leg_cond_eval.sv
// Combinational condition evaluator: decodes the low six opcode bits and
// compares the two operands unsigned or two's complement. Unknown codes
// evaluate to false.
module leg_cond_eval
  import leg_branch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [5:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken
);

  // Select the comparison named by the opcode.
  always_comb begin
    taken = 1'b0;
    case (op)
      COND_EQ:  taken = (a == b);
      COND_NE:  taken = (a != b);
      COND_LTU: taken = (a <  b);
      COND_LEU: taken = (a <= b);
      COND_GTU: taken = (a >  b);
      COND_GEU: taken = (a >= b);
      COND_LTS: taken = ($signed(a) <  $signed(b));
      COND_LES: taken = ($signed(a) <= $signed(b));
      COND_GTS: taken = ($signed(a) >  $signed(b));
      COND_GES: taken = ($signed(a) >= $signed(b));
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/leg_branch_ctrl.sv
// LEG program-counter owner and branch sequencer. Holds the PC, steps it on
// fetch requests, and resolves one conditional branch at a time through an
// IDLE -> EVAL -> (FLUSH) -> IDLE sequence. A taken branch loads the target
// and pulses flush for FLUSH_CYCLES cycles.
// Optional feature: define LEG_BRANCH_STATS_EN to build the saturating
// resolved/taken branch counters; otherwise stat_total/stat_taken are tied 0.
module leg_branch_ctrl
  import leg_branch_pkg::*;
#(
  parameter int PC_W         = 8,
  parameter int DATA_W       = 8,
  parameter int INSTR_BYTES  = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int RESET_PC     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  leg_branch_if.slave     bus,
  output logic [PC_W-1:0] pc,
  output logic            stall,
  output logic            flush,
  output logic            br_done,
  output logic            br_taken,
  output logic [15:0]     stat_total,
  output logic [15:0]     stat_taken
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0]  PC_RST     = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [5:0]        op_q, op_d;
  logic [DATA_W-1:0] arg1_q, arg1_d;
  logic [DATA_W-1:0] arg2_q, arg2_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              br_done_q, br_done_d;
  logic              br_taken_q, br_taken_d;
  logic              cond_taken;
  logic              unused_op_hi;

  // Opcode bits [7:6] carry no meaning for the condition decode.
  assign unused_op_hi = ^bus.in_op[7:6];

  leg_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
    .op    (op_q),
    .a     (arg1_q),
    .b     (arg2_q),
    .taken (cond_taken)
  );

  // Next-state, PC and branch-result logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    op_d        = op_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    flush_cnt_d = flush_cnt_q;
    br_done_d   = 1'b0;
    br_taken_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d     = bus.in_op[5:0];
          arg1_d   = bus.in_arg1;
          arg2_d   = bus.in_arg2;
          target_d = bus.in_target;
          state_d  = EVAL;
        end else if (advance) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      EVAL: begin
        br_done_d = 1'b1;
        if (cond_taken) begin
          br_taken_d  = 1'b1;
          pc_d        = target_q;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= CNT_ONE) begin
          flush_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any branch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= PC_RST;
      target_q    <= '0;
      op_q        <= '0;
      arg1_q      <= '0;
      arg2_q      <= '0;
      flush_cnt_q <= '0;
      br_done_q   <= 1'b0;
      br_taken_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      op_q        <= op_d;
      arg1_q      <= arg1_d;
      arg2_q      <= arg2_d;
      flush_cnt_q <= flush_cnt_d;
      br_done_q   <= br_done_d;
      br_taken_q  <= br_taken_d;
    end
  end

  assign pc           = pc_q;
  assign stall        = (state_q != IDLE);
  assign flush        = (state_q == FLUSH);
  assign br_done      = br_done_q;
  assign br_taken     = br_taken_q;
  assign bus.in_ready = (state_q == IDLE);

`ifdef LEG_BRANCH_STATS_EN
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_taken_q, stat_taken_d;

  // Counters step in the same cycle the result registers are loaded.
  always_comb begin
    stat_total_d = stat_total_q;
    stat_taken_d = stat_taken_q;
    if (br_done_d) stat_total_d = sat_inc16(stat_total_q);
    if (br_taken_d) stat_taken_d = sat_inc16(stat_taken_q);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_total_q <= '0;
      stat_taken_q <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_taken_q <= stat_taken_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_taken = stat_taken_q;
`else
  assign stat_total = '0;
  assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_leg_branch_ctrl.sv
// Self-checking bench for leg_branch_ctrl: a cycle-timestamp model of the
// branch rules is compared against the DUT on every falling edge, plus
// hand-computed literal checks after each directed step.
module tb_leg_branch_ctrl;

  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance;
  logic [7:0]  pc;
  logic        stall, flush, br_done, br_taken;
  logic [15:0] stat_total, stat_taken;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Model state, expressed as cycle timestamps of upcoming events.
  int         cyc        = 0;
  int         free_at    = 0;
  int         done_at    = -1;
  int         flush_from = 0;
  int         flush_to   = -1;
  bit         done_taken = 1'b0;
  logic [7:0] m_pc       = 8'h00;
  logic [7:0] pend_pc    = 8'h00;
  int         m_total    = 0;
  int         m_taken    = 0;

  leg_branch_if #(.PC_W(8), .DATA_W(8)) bus ();

  leg_branch_ctrl #(
    .PC_W(8), .DATA_W(8), .INSTR_BYTES(4), .FLUSH_CYCLES(FLUSH_N), .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .bus        (bus),
    .pc         (pc),
    .stall      (stall),
    .flush      (flush),
    .br_done    (br_done),
    .br_taken   (br_taken),
    .stat_total (stat_total),
    .stat_taken (stat_taken)
  );

  always #5 clk = ~clk;

  function automatic bit modelTaken(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    case (int'(op) % 64)
      32: return ua == ub;
      33: return ua != ub;
      34: return ua < ub;
      35: return ua <= ub;
      36: return ua > ub;
      37: return ua >= ub;
      38: return sa < sb;
      39: return sa <= sb;
      40: return sa > sb;
      41: return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] tgt, input logic adv);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_arg1   = a;
    bus.in_arg2   = b;
    bus.in_target = tgt;
    advance       = adv;
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // Model update at each rising edge, using the inputs of the cycle that ends.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pc       = 8'h00;
        free_at    = 0;
        done_at    = -1;
        flush_from = 0;
        flush_to   = -1;
        done_taken = 1'b0;
        m_total    = 0;
        m_taken    = 0;
        cyc        = 0;
      end else begin
        if (cyc == done_at - 1) begin
          m_pc = pend_pc;
          if (m_total < 65535) m_total++;
          if (done_taken && m_taken < 65535) m_taken++;
        end else if (cyc >= free_at) begin
          if (bus.in_valid === 1'b1) begin
            done_taken = modelTaken(bus.in_op, bus.in_arg1, bus.in_arg2);
            done_at    = cyc + 2;
            pend_pc    = done_taken ? bus.in_target : m_pc + 8'd4;
            free_at    = cyc + 2 + (done_taken ? FLUSH_N : 0);
            if (done_taken) begin
              flush_from = cyc + 2;
              flush_to   = cyc + 1 + FLUSH_N;
            end
          end else if (advance === 1'b1) begin
            m_pc = m_pc + 8'd4;
          end
        end
        cyc++;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    logic [15:0] exp_total, exp_taken;
    forever begin
      @(negedge clk);
      if (checking) begin
`ifdef LEG_BRANCH_STATS_EN
        exp_total = 16'(m_total);
        exp_taken = 16'(m_taken);
`else
        exp_total = 16'h0;
        exp_taken = 16'h0;
`endif
        checkOutput("pc", 16'(pc), 16'(m_pc));
        checkOutput("stall", 16'(stall), 16'(cyc < free_at));
        checkOutput("in_ready", 16'(bus.in_ready), 16'(!(cyc < free_at)));
        checkOutput("flush", 16'(flush), 16'(cyc >= flush_from && cyc <= flush_to));
        checkOutput("br_done", 16'(br_done), 16'(cyc == done_at));
        checkOutput("br_taken", 16'(br_taken), 16'(cyc == done_at && done_taken));
        checkOutput("stat_total", stat_total, exp_total);
        checkOutput("stat_taken", stat_taken, exp_taken);
      end
    end
  end

  // Directed sequence with literal expectations.
  initial begin
    rst           = 1'b0;
    advance       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 8'h00;
    bus.in_arg1   = 8'h00;
    bus.in_arg2   = 8'h00;
    bus.in_target = 8'h00;
    @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("reset_pc", 16'(pc), 16'h0000);
    checkOutput("reset_ready", 16'(bus.in_ready), 16'h0001);
    checkOutput("reset_flush", 16'(flush), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fetch steps.
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("adv1_pc", 16'(pc), 16'h0004);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("adv2_pc", 16'(pc), 16'h0008);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("adv3_pc", 16'(pc), 16'h000C);

    // EQ taken.
    applyStimulus(1'b1, 8'h20, 8'h05, 8'h05, 8'h40, 1'b0);
    checkOutput("eq_ready_low", 16'(bus.in_ready), 16'h0000);
    checkOutput("eq_pc_hold", 16'(pc), 16'h000C);
    idleStep();
    checkOutput("eq_done", 16'(br_done), 16'h0001);
    checkOutput("eq_taken", 16'(br_taken), 16'h0001);
    checkOutput("eq_pc", 16'(pc), 16'h0040);
    checkOutput("eq_flush1", 16'(flush), 16'h0001);
    idleStep();
    checkOutput("eq_flush2", 16'(flush), 16'h0001);
    idleStep();
    checkOutput("eq_flush_end", 16'(flush), 16'h0000);
    checkOutput("eq_ready_back", 16'(bus.in_ready), 16'h0001);

    // LTS taken vs LTU not taken on the same operands.
    applyStimulus(1'b1, 8'h26, 8'hFF, 8'h01, 8'h80, 1'b0);
    idleStep();
    checkOutput("lts_taken", 16'(br_taken), 16'h0001);
    checkOutput("lts_pc", 16'(pc), 16'h0080);
    idleStep();
    idleStep();
    applyStimulus(1'b1, 8'h22, 8'hFF, 8'h01, 8'h10, 1'b0);
    idleStep();
    checkOutput("ltu_done", 16'(br_done), 16'h0001);
    checkOutput("ltu_taken", 16'(br_taken), 16'h0000);
    checkOutput("ltu_pc", 16'(pc), 16'h0084);

    // Wrap: jump to 0xFC, then a not-taken NE steps to 0x00.
    applyStimulus(1'b1, 8'h20, 8'h00, 8'h00, 8'hFC, 1'b0);
    idleStep();
    idleStep();
    idleStep();
    checkOutput("fc_pc", 16'(pc), 16'h00FC);
    applyStimulus(1'b1, 8'h21, 8'h03, 8'h03, 8'h55, 1'b0);
    idleStep();
    checkOutput("ne_taken", 16'(br_taken), 16'h0000);
    checkOutput("wrap_pc", 16'(pc), 16'h0000);
    applyStimulus(1'b1, 8'hE0, 8'h07, 8'h07, 8'h22, 1'b0);
    idleStep();
    checkOutput("masked_taken", 16'(br_taken), 16'h0001);
    checkOutput("masked_pc", 16'(pc), 16'h0022);
    idleStep();
    idleStep();

    // Branch beats advance; advance ignored during flush.
    applyStimulus(1'b1, 8'h24, 8'h02, 8'h01, 8'h30, 1'b1);
    checkOutput("prio_pc_hold", 16'(pc), 16'h0022);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("gtu_pc", 16'(pc), 16'h0030);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("flush_adv_pc", 16'(pc), 16'h0030);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("post_flush_pc", 16'(pc), 16'h0030);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("resume_adv_pc", 16'(pc), 16'h0034);

    // Request held high through EVAL is not re-accepted there.
    applyStimulus(1'b1, 8'h23, 8'h01, 8'h01, 8'h60, 1'b0);
    applyStimulus(1'b1, 8'h23, 8'h01, 8'h01, 8'h60, 1'b0);
    checkOutput("held_pc", 16'(pc), 16'h0060);
    idleStep();
    idleStep();
    checkOutput("held_ready", 16'(bus.in_ready), 16'h0001);

    // Reset during FLUSH.
    applyStimulus(1'b1, 8'h25, 8'h03, 8'h03, 8'h70, 1'b0);
    idleStep();
    rst = 1'b0;
    #1;
    checkOutput("rstf_pc", 16'(pc), 16'h0000);
    checkOutput("rstf_flush", 16'(flush), 16'h0000);
    checkOutput("rstf_done", 16'(br_done), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset during EVAL loses the branch.
    applyStimulus(1'b1, 8'h20, 8'h01, 8'h01, 8'h90, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("rste_stall", 16'(stall), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    idleStep();
    checkOutput("rste_done", 16'(br_done), 16'h0000);
    checkOutput("rste_pc", 16'(pc), 16'h0000);

    // Four branches, two taken.
    applyStimulus(1'b1, 8'h20, 8'h01, 8'h01, 8'h10, 1'b0);
    idleStep();
    idleStep();
    idleStep();
    applyStimulus(1'b1, 8'h21, 8'h01, 8'h01, 8'h99, 1'b0);
    idleStep();
    checkOutput("s_ne_pc", 16'(pc), 16'h0014);
    applyStimulus(1'b1, 8'h26, 8'h80, 8'h00, 8'h20, 1'b0);
    idleStep();
    checkOutput("s_lts_pc", 16'(pc), 16'h0020);
    idleStep();
    idleStep();
    applyStimulus(1'b1, 8'h29, 8'h80, 8'h00, 8'hAA, 1'b0);
    idleStep();
    checkOutput("s_ges_pc", 16'(pc), 16'h0024);
`ifdef LEG_BRANCH_STATS_EN
    checkOutput("stat_total4", stat_total, 16'd4);
    checkOutput("stat_taken2", stat_taken, 16'd2);
`else
    checkOutput("stat_total_off", stat_total, 16'd0);
    checkOutput("stat_taken_off", stat_taken, 16'd0);
`endif
    idleStep();
    idleStep();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
